// File: rtl/dmem_wait_if.sv
// Data-memory interface for the Memory stage with programmable wait states.
// Ports: clk, reset (sync, active-low); req/we/be/addr/wdata request from the
// M stage; rdata/ack/err registered completion; stall (combinational) to hazard unit.
module dmem_wait_if #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        stall
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic          acc_we;
    logic [3:0]    acc_be;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [AW-1:0] acc_idx;
    logic          misaligned;
    logic          enter_done;
    logic          mem_we;

    // Upper address bits wrap; they intentionally feed nothing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[31:AW+2]};

    always_comb begin
        // In IDLE the live inputs are the access (needed when WAIT_STATES=0,
        // where the DONE-entry edge is the accept edge); later use the latch.
        if (state_q == IDLE) begin
            acc_we    = we;
            acc_be    = be;
            acc_addr  = addr;
            acc_wdata = wdata;
        end else begin
            acc_we    = we_q;
            acc_be    = be_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_idx    = acc_addr[AW+1:2];
        misaligned = (acc_be == 4'hF) && (acc_addr[1:0] != 2'b00);

        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        enter_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    be_d    = be;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CNT_INIT;
                    if (WAIT_STATES == 0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (enter_done) begin
            ack_d = 1'b1;
            err_d = misaligned;
            if (!acc_we) begin
                rdata_d = misaligned ? 32'h0 : mem[acc_idx];
            end
        end

        mem_we = enter_done && acc_we && !misaligned;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // RAM is never cleared; a reset on the DONE-entry edge cancels the write.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign stall = ((state_q == IDLE) && req) || (state_q == BUSY);
    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_wait_if.sv
// Scoreboard bench for dmem_wait_if.
// Main instance uses WAIT_STATES=2; a second instance uses WAIT_STATES=0.
module tb_dmem_wait_if;

    localparam int DEPTH = 64;
    localparam int WS    = 2;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        ack, err, stall;

    logic        req1, we1;
    logic [3:0]  be1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        ack1, err1, stall1;

    dmem_wait_if #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .be(be),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack),
        .err(err), .stall(stall)
    );

    dmem_wait_if #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .be(be1),
        .addr(addr1), .wdata(wdata1), .rdata(rdata1), .ack(ack1),
        .err(err1), .stall(stall1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_rdata = 32'h0;

    // Scoreboard consumer: every ack of the main instance retires one entry.
    exp_t e;
    always @(negedge clk) begin
        if (reset && ack === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                n_tests++;
                if (rdata !== e.rdata) begin
                    n_fail++;
                    $display("FAIL sb_rdata got %h want %h", rdata, e.rdata);
                end
                n_tests++;
                if (err !== e.err) begin
                    n_fail++;
                    $display("FAIL sb_err got %b want %b", err, e.err);
                end
            end
        end
    end

    task automatic push_exp(input logic w, input logic [3:0] b,
                            input logic [31:0] a, input logic [31:0] d);
        logic     mis;
        int       idx;
        exp_t     x;
        mis = (b == 4'hF) && (a[1:0] != 2'b00);
        idx = int'(a[AW+1:2]);
        if (w) begin
            if (!mis) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) model[idx][8*i +: 8] = d[8*i +: 8];
            end
        end else begin
            last_rdata = mis ? 32'h0 : model[idx];
        end
        x.rdata = last_rdata;
        x.err   = mis;
        sb.push_back(x);
    endtask

    // Leaves req high on return so a following call is back-to-back.
    task automatic do_access(input logic w, input logic [3:0] b,
                             input logic [31:0] a, input logic [31:0] d,
                             output int ack_cyc);
        int t;
        int lat;
        @(posedge clk); #1;
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        push_exp(w, b, a, d);
        t = cyc;
        lat = -1;
        ack_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                lat = cyc - t;
                ack_cyc = cyc;
                break;
            end
            n_tests++;
            if (stall !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_wait got %b want 1 (k=%0d)", stall, k);
            end
        end
        n_tests++;
        if (lat != WS + 1) begin
            n_fail++;
            $display("FAIL latency got %0d want %0d", lat, WS + 1);
        end
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done got %b want 0", stall);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        req = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req = 0; we = 0; be = 0; addr = 0; wdata = 0;
        req1 = 0; we1 = 0; be1 = 0; addr1 = 0; wdata1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({ack, err, stall, rdata} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_main got ack=%b err=%b stall=%b rdata=%h want 0",
                     ack, err, stall, rdata);
        end
        n_tests++;
        if ({ack1, err1, stall1, rdata1} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_ws0 got ack=%b err=%b stall=%b rdata=%h want 0",
                     ack1, err1, stall1, rdata1);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        last_rdata = 32'h0;
    endtask

    task automatic test_basic;
        int a1, a2;
        do_access(1'b1, 4'hF, 32'h8, 32'hDEADBEEF, a1);
        do_access(1'b0, 4'hF, 32'h8, 32'h0, a2);
        n_tests++;
        if (a2 - a1 != WS + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing got %0d want %0d", a2 - a1, WS + 2);
        end
        idle(2);
    endtask

    task automatic test_bytes;
        int c;
        do_access(1'b1, 4'hF, 32'h10, 32'h11223344, c);
        do_access(1'b1, 4'b0100, 32'h10, 32'h00AA0000, c);
        do_access(1'b0, 4'hF, 32'h10, 32'h0, c);
        idle(2);
    endtask

    task automatic test_misaligned;
        int c;
        do_access(1'b1, 4'hF, 32'h4, 32'hCAFEF00D, c);
        do_access(1'b0, 4'hF, 32'h4, 32'h0, c);
        do_access(1'b0, 4'hF, 32'h6, 32'h0, c);
        do_access(1'b1, 4'hF, 32'h6, 32'hFFFFFFFF, c);
        do_access(1'b1, 4'h0, 32'h4, 32'h12345678, c);
        do_access(1'b0, 4'hF, 32'h4, 32'h0, c);
        idle(2);
    endtask

    task automatic test_wrap;
        int c;
        do_access(1'b1, 4'hF, 32'h100, 32'h5A5A5A5A, c);
        do_access(1'b0, 4'hF, 32'h0, 32'h0, c);
        idle(2);
    endtask

    task automatic test_latched;
        bit seen;
        int c;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h10; wdata = 32'h0;
        push_exp(1'b0, 4'hF, 32'h10, 32'h0);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b1; addr = 32'h8; wdata = 32'hFFFFFFFF;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL latched_ack got none want ack");
        end
        idle(2);
        do_access(1'b0, 4'hF, 32'h8, 32'h0, c);
        idle(2);
    endtask

    task automatic test_reset_mid;
        bit any_ack;
        int c;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h8; wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        reset = 1'b0;
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        last_rdata = 32'h0;
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_stall got %b want 0", stall);
        end
        n_tests++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_rdata got %h want 0", rdata);
        end
        any_ack = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (ack !== 1'b0) any_ack = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (any_ack) begin
            n_fail++;
            $display("FAIL reset_mid_ack got 1 want 0");
        end
        do_access(1'b0, 4'hF, 32'h8, 32'h0, c);
        idle(2);
    endtask

    task automatic test_back_to_back;
        logic exp_ack [4];
        logic exp_stall [4];
        exp_ack   = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_stall = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                req1 = 1'b1; we1 = 1'b1; be1 = 4'hF;
                addr1 = 32'h20; wdata1 = 32'h13572468;
            end else if (k == 1) begin
                we1 = 1'b0;
            end else if (k == 3) begin
                req1 = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if (ack1 !== exp_ack[k]) begin
                n_fail++;
                $display("FAIL ws0_ack[%0d] got %b want %b", k, ack1, exp_ack[k]);
            end
            n_tests++;
            if (stall1 !== exp_stall[k]) begin
                n_fail++;
                $display("FAIL ws0_stall[%0d] got %b want %b", k, stall1, exp_stall[k]);
            end
        end
        n_tests++;
        if (rdata1 !== 32'h13572468) begin
            n_fail++;
            $display("FAIL ws0_rdata got %h want 13572468", rdata1);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_bytes();
        test_misaligned();
        test_wrap();
        test_latched();
        test_reset_mid();
        test_back_to_back();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
